// File: rtl/jc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jc_seq_ctrl
// Brief    : Sequencer for a 4-bit Johnson counter. It clears the counter and
//            then issues a prescaled ce for a programmed number of revolutions,
//            using a start/busy/done handshake. The optional q legality
//            checker is enabled by the JC_CHECK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module jc_seq_ctrl #(
    parameter int DIV = 4,
    parameter int NW  = 8
) (
    input  logic          clk,
    input  logic          R,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] n_rev,
    input  logic          tc,
    input  logic [3:0]    q,
    output logic          cnt_ce,
    output logic          cnt_R,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] rev_cnt,
    output logic          err
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [NW-1:0] n_lat_q, n_lat_d;
    logic [NW-1:0] rev_q, rev_d;
    logic          cnt_ce_q, cnt_ce_d;
    logic          cnt_r_q, cnt_r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          start_ok;
    logic          rev_event;
    logic [NW-1:0] rev_inc;

    assign start_ok  = start & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign rev_event = (state_q == S_RUN) & cnt_ce_q & tc & ~abort;
    assign rev_inc   = rev_q + NW'(1);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        n_lat_d = n_lat_q;
        rev_d   = rev_q;

        if (abort) begin
            state_d = S_IDLE;
            pre_d   = '0;
            rev_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_lat_d = n_rev;
                        rev_d   = '0;
                        pre_d   = '0;
                        state_d = S_CLR;
                    end
                end
                S_CLR: begin
                    state_d = (n_lat_q == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                    // The compare fires before rev_cnt could ever wrap.
                    if (rev_event) begin
                        rev_d = rev_inc;
                        if (rev_inc == n_lat_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they appear registered.
        cnt_ce_d = (state_d == S_RUN) && (pre_d == PRE_LAST);
        cnt_r_d  = (state_d == S_CLR);
        busy_d   = (state_d == S_CLR) || (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            n_lat_q  <= '0;
            rev_q    <= '0;
            cnt_ce_q <= 1'b0;
            cnt_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            n_lat_q  <= n_lat_d;
            rev_q    <= rev_d;
            cnt_ce_q <= cnt_ce_d;
            cnt_r_q  <= cnt_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // abort must stop the counter in the very cycle it is raised.
    assign cnt_ce  = cnt_ce_q & ~abort;
    assign cnt_R   = cnt_r_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rev_cnt = rev_q;

`ifdef JC_CHECK_EN
    logic err_q, err_d;
    logic chk_sup_q, chk_sup_d;
    logic q_legal;

    always_comb begin
        case (q)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: q_legal = 1'b1;
            default:                            q_legal = 1'b0;
        endcase

        // Counter output may still be settling right after the clear.
        chk_sup_d = (state_q == S_CLR);

        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (((state_q == S_RUN) || (state_q == S_DONE)) && !chk_sup_q && !q_legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            err_q     <= 1'b0;
            chk_sup_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            chk_sup_q <= chk_sup_d;
        end
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{q, start_ok};
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire
